// File: rtl/half_sub_struct.sv
// Structural 1-bit half subtractor (A - Bin) with registered copy and saturating borrow counter.
// Optional build macro HALF_SUB_SELFCHECK_EN adds a sticky chk_err output fed by a behavioural reference.
module half_sub_struct #(
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             Bin,
  output logic             D,
  output logic             Bout,
  output logic             D_q,
  output logic             Bout_q,
  output logic [CNT_W-1:0] borrow_cnt,
  output logic             cnt_sat
`ifdef HALF_SUB_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  logic             a_n;
  logic [CNT_W-1:0] cnt_reg;

  // Gate-level core: valid regardless of clock or reset.
  xor g_xor (D, A, Bin);
  not g_not (a_n, A);
  and g_and (Bout, a_n, Bin);

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic d_q_reg;
      logic bout_q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q_reg    <= 1'b0;
          bout_q_reg <= 1'b0;
        end else begin
          d_q_reg    <= D;
          bout_q_reg <= Bout;
        end
      end

      assign D_q    = d_q_reg;
      assign Bout_q = bout_q_reg;
    end else begin : g_no_reg_out
      assign D_q    = 1'b0;
      assign Bout_q = 1'b0;
    end
  endgenerate

  assign cnt_sat    = &cnt_reg;
  assign borrow_cnt = cnt_reg;

  // Count borrow edges, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (Bout && !cnt_sat) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

`ifdef HALF_SUB_SELFCHECK_EN
  logic [1:0] ref_diff;
  logic       chk_err_reg;

  assign ref_diff = {1'b0, A} - {1'b0, Bin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_reg <= 1'b0;
    end else if ({Bout, D} != ref_diff) begin
      chk_err_reg <= 1'b1;
    end
  end

  assign chk_err = chk_err_reg;
`endif

endmodule

// File: tb/tb_half_sub_struct.sv
// Randomised, model-checked bench for half_sub_struct (CNT_W=3 registered instance plus CNT_W=8 unregistered instance).
module tb_half_sub_struct;
  localparam int CW_A  = 3;
  localparam int CW_B  = 8;
  localparam int MAX_A = (1 << CW_A) - 1;
  localparam int MAX_B = (1 << CW_B) - 1;

  logic            clk = 1'b0;
  logic            clk_en = 1'b0;
  logic            rst_n = 1'b0;
  logic            A = 1'b0;
  logic            Bin = 1'b0;
  logic            d_a, bout_a, dq_a, bq_a, sat_a;
  logic            d_b, bout_b, dq_b, bq_b, sat_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;
`ifdef HALF_SUB_SELFCHECK_EN
  logic            err_a, err_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model state (plain integers).
  int m_cnt_a = 0;
  int m_cnt_b = 0;
  int m_dq    = 0;
  int m_bq    = 0;

  half_sub_struct #(.CNT_W(CW_A), .REG_OUT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .A(A), .Bin(Bin),
    .D(d_a), .Bout(bout_a), .D_q(dq_a), .Bout_q(bq_a),
    .borrow_cnt(cnt_a), .cnt_sat(sat_a)
`ifdef HALF_SUB_SELFCHECK_EN
    , .chk_err(err_a)
`endif
  );

  half_sub_struct #(.CNT_W(CW_B), .REG_OUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .A(A), .Bin(Bin),
    .D(d_b), .Bout(bout_b), .D_q(dq_b), .Bout_q(bq_b),
    .borrow_cnt(cnt_b), .cnt_sat(sat_b)
`ifdef HALF_SUB_SELFCHECK_EN
    , .chk_err(err_b)
`endif
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int diff_of(input logic a, input logic b);
    return int'(a) - int'(b);
  endfunction

  // Model: a borrow is simply a negative difference.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt_a <= 0;
      m_cnt_b <= 0;
      m_dq    <= 0;
      m_bq    <= 0;
    end else begin
      m_dq <= (diff_of(A, Bin) != 0) ? 1 : 0;
      m_bq <= (diff_of(A, Bin) < 0) ? 1 : 0;
      if (diff_of(A, Bin) < 0) begin
        m_cnt_a <= (m_cnt_a < MAX_A) ? m_cnt_a + 1 : MAX_A;
        m_cnt_b <= (m_cnt_b < MAX_B) ? m_cnt_b + 1 : MAX_B;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int df;
      df = diff_of(A, Bin);
      check("D_a",      32'(d_a),    32'(df != 0));
      check("Bout_a",   32'(bout_a), 32'(df < 0));
      check("D_b",      32'(d_b),    32'(df != 0));
      check("Bout_b",   32'(bout_b), 32'(df < 0));
      check("D_q_a",    32'(dq_a),   32'(m_dq));
      check("Bout_q_a", 32'(bq_a),   32'(m_bq));
      check("D_q_b",    32'(dq_b),   32'd0);
      check("Bout_q_b", 32'(bq_b),   32'd0);
      check("cnt_a",    32'(cnt_a),  32'(m_cnt_a));
      check("cnt_b",    32'(cnt_b),  32'(m_cnt_b));
      check("sat_a",    32'(sat_a),  32'(m_cnt_a == MAX_A));
      check("sat_b",    32'(sat_b),  32'(m_cnt_b == MAX_B));
`ifdef HALF_SUB_SELFCHECK_EN
      check("chk_err_a", 32'(err_a), 32'd0);
      check("chk_err_b", 32'(err_b), 32'd0);
`endif
    end
  end

  task automatic step_in(input logic a, input logic b);
    @(posedge clk);
    #2;
    A   = a;
    Bin = b;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_tab;
  initial begin
    // Exhaustive combinational check with the clock stopped and reset held.
    exp_tab = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      A   = i[1];
      Bin = i[0];
      #10;
      exp_tab = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0011 : (i == 2) ? 4'b0010 : 4'b0000;
      check("comb_D",    32'(d_a),    32'(exp_tab[1]));
      check("comb_Bout", 32'(bout_a), 32'(exp_tab[0]));
    end
    check("rst_D_q",    32'(dq_a),  32'd0);
    check("rst_Bout_q", 32'(bq_a),  32'd0);
    check("rst_cnt",    32'(cnt_a), 32'd0);
    check("rst_sat",    32'(sat_a), 32'd0);

    A = 1'b0;
    Bin = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Latency: one cycle from inputs to D_q/Bout_q.
    step_in(1'b0, 1'b1);
    @(posedge clk); #1;
    check("lat_D_q_1",    32'(dq_a), 32'd1);
    check("lat_Bout_q_1", 32'(bq_a), 32'd1);
    #1;
    A = 1'b1;
    Bin = 1'b1;
    @(posedge clk); #1;
    check("lat_D_q_2",    32'(dq_a), 32'd0);
    check("lat_Bout_q_2", 32'(bq_a), 32'd0);

    // Saturation at 7 for the 3-bit counter.
    reset_pulse();
    A = 1'b0;
    Bin = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("sat_cnt", 32'(cnt_a), 32'((k < 7) ? k : 7));
      check("sat_flag", 32'(sat_a), 32'(k >= 7));
    end

    // No borrow, no count.
    #1;
    A = 1'b1;
    Bin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("gate_cnt",  32'(cnt_a),  32'd7);
      check("gate_D",    32'(d_a),    32'd1);
      check("gate_Bout", 32'(bout_a), 32'd0);
    end

    // Asynchronous reset between edges with count at 5.
    reset_pulse();
    A = 1'b0;
    Bin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_cnt", 32'(cnt_a), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_cnt",    32'(cnt_a), 32'd0);
    check("async_D_q",    32'(dq_a),  32'd0);
    check("async_Bout_q", 32'(bq_a),  32'd0);
    check("async_sat",    32'(sat_a), 32'd0);
    A = 1'b1;
    Bin = 1'b0;
    #1;
    check("async_D",    32'(d_a),    32'd1);
    check("async_Bout", 32'(bout_a), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Random traffic with occasional mid-cycle resets.
    for (int k = 0; k < 300; k++) begin
      step_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #6;
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
